// File: rtl/control_unit.sv
// Multi-cycle LEGv8 control unit: alternates FETCH/EXECUTE, latches the instruction
// into IR, and decodes it into a 64-bit datapath control word plus extended constant.
module control_unit (
    input  logic        c,
    input  logic        r,
    input  logic [31:0] in,
    input  logic [3:0]  stat,
    output logic [63:0] con,
    output logic [31:0] out
);

    typedef enum logic {
        FETCH   = 1'b0,
        EXECUTE = 1'b1
    } state_t;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_EOR  = 11'b11001010000;
    localparam logic [10:0] OP_ADDS = 11'b10101011000;
    localparam logic [10:0] OP_SUBS = 11'b11101011000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;

    localparam logic [9:0]  OP_ADDI = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI = 10'b1101000100;
    localparam logic [9:0]  OP_ANDI = 10'b1001001000;
    localparam logic [9:0]  OP_ORRI = 10'b1011001000;
    localparam logic [9:0]  OP_EORI = 10'b1101001000;

    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ = 8'b10110101;
    localparam logic [5:0]  OP_B    = 6'b000101;

    localparam logic [4:0]  FS_AND = 5'd0;
    localparam logic [4:0]  FS_ORR = 5'd1;
    localparam logic [4:0]  FS_ADD = 5'd2;
    localparam logic [4:0]  FS_EOR = 5'd3;
    localparam logic [4:0]  FS_SUB = 5'd6;

    state_t      state;
    state_t      state_next;
    logic [31:0] ir;

    logic        is_r;
    logic        is_i;
    logic [4:0]  r_fs;
    logic [4:0]  i_fs;
    logic        r_sl;

    logic [4:0]  da;
    logic [4:0]  sa;
    logic [4:0]  sb;
    logic [4:0]  fs;
    logic        rw;
    logic        bs;
    logic        mw;
    logic        mr;
    logic [1:0]  ds;
    logic        il;
    logic [1:0]  ps;
    logic        sl;
    logic        addr_pc;
    logic [31:0] imm;

    logic        unused_flags;
    assign unused_flags = ^stat[3:1];

    always_ff @(posedge c or negedge r) begin
        if (!r) begin
            state <= FETCH;
            ir    <= '0;
        end else begin
            state <= state_next;
            if (state == FETCH) begin
                ir <= in;
            end
        end
    end

    // Opcode classification for the two table-driven instruction groups.
    always_comb begin
        is_r = 1'b0;
        r_fs = FS_AND;
        r_sl = 1'b0;
        case (ir[31:21])
            OP_ADD:  begin is_r = 1'b1; r_fs = FS_ADD; end
            OP_SUB:  begin is_r = 1'b1; r_fs = FS_SUB; end
            OP_AND:  begin is_r = 1'b1; r_fs = FS_AND; end
            OP_ORR:  begin is_r = 1'b1; r_fs = FS_ORR; end
            OP_EOR:  begin is_r = 1'b1; r_fs = FS_EOR; end
            OP_ADDS: begin is_r = 1'b1; r_fs = FS_ADD; r_sl = 1'b1; end
            OP_SUBS: begin is_r = 1'b1; r_fs = FS_SUB; r_sl = 1'b1; end
            default: ;
        endcase

        is_i = 1'b0;
        i_fs = FS_AND;
        case (ir[31:22])
            OP_ADDI: begin is_i = 1'b1; i_fs = FS_ADD; end
            OP_SUBI: begin is_i = 1'b1; i_fs = FS_SUB; end
            OP_ANDI: begin is_i = 1'b1; i_fs = FS_AND; end
            OP_ORRI: begin is_i = 1'b1; i_fs = FS_ORR; end
            OP_EORI: begin is_i = 1'b1; i_fs = FS_EOR; end
            default: ;
        endcase
    end

    always_comb begin
        state_next = state;
        da      = '0;
        sa      = '0;
        sb      = '0;
        fs      = '0;
        rw      = 1'b0;
        bs      = 1'b0;
        mw      = 1'b0;
        mr      = 1'b0;
        ds      = 2'b00;
        il      = 1'b0;
        ps      = 2'b00;
        sl      = 1'b0;
        addr_pc = 1'b0;
        imm     = '0;

        case (state)
            FETCH: begin
                state_next = EXECUTE;
                il      = 1'b1;
                ps      = 2'b01;
                addr_pc = 1'b1;
                mr      = 1'b1;
            end
            EXECUTE: begin
                state_next = FETCH;
                if (is_r) begin
                    da = ir[4:0];
                    sa = ir[9:5];
                    sb = ir[20:16];
                    fs = r_fs;
                    rw = 1'b1;
                    sl = r_sl;
                end else if (is_i) begin
                    da  = ir[4:0];
                    sa  = ir[9:5];
                    fs  = i_fs;
                    rw  = 1'b1;
                    bs  = 1'b1;
                    imm = {20'b0, ir[21:10]};
                end else if (ir[31:21] == OP_LDUR) begin
                    da  = ir[4:0];
                    sa  = ir[9:5];
                    fs  = FS_ADD;
                    bs  = 1'b1;
                    mr  = 1'b1;
                    ds  = 2'b01;
                    rw  = 1'b1;
                    imm = {{23{ir[20]}}, ir[20:12]};
                end else if (ir[31:21] == OP_STUR) begin
                    sa  = ir[9:5];
                    sb  = ir[4:0];
                    fs  = FS_ADD;
                    bs  = 1'b1;
                    mw  = 1'b1;
                    imm = {{23{ir[20]}}, ir[20:12]};
                end else if (ir[31:26] == OP_B) begin
                    ps  = 2'b10;
                    imm = {{6{ir[25]}}, ir[25:0]};
                end else if ((ir[31:24] == OP_CBZ) || (ir[31:24] == OP_CBNZ)) begin
                    // ir[24] distinguishes CBNZ; branch when Z matches the wanted polarity.
                    sa  = 5'd31;
                    sb  = ir[4:0];
                    fs  = FS_ADD;
                    imm = {{13{ir[23]}}, ir[23:5]};
                    if (stat[0] != ir[24]) begin
                        ps = 2'b10;
                    end
                end
            end
            default: state_next = FETCH;
        endcase
    end

    // Reset forces the outputs low even though the FSM is parked in FETCH.
    assign con = r ? {33'b0, addr_pc, sl, ps, il, ds, mr, mw, bs, rw, fs, sb, sa, da} : 64'b0;
    assign out = r ? imm : 32'b0;

endmodule

// File: tb/tb_control_unit.sv
// Randomized scoreboard bench for control_unit: a spec-level reference model predicts
// each cycle's control word and constant, and a negedge monitor compares them.
module tb_control_unit;

    logic        c;
    logic        r;
    logic [31:0] in;
    logic [3:0]  stat;
    logic [63:0] con;
    logic [31:0] out;

    int          checks;
    int          errors;
    logic [95:0] sb_q[$];
    bit          model_fetch;
    logic [31:0] model_ir;

    control_unit dut (
        .c    (c),
        .r    (r),
        .in   (in),
        .stat (stat),
        .con  (con),
        .out  (out)
    );

    initial c = 1'b0;
    always #5 c = ~c;

    function automatic logic [31:0] sext(input longint unsigned v, input int bits);
        longint s;
        s = longint'(v);
        if (v >= (longint'(1) << (bits - 1))) s = s - (longint'(1) << bits);
        return s[31:0];
    endfunction

    // Reference EXECUTE behaviour: fields summed as weighted numbers from the instruction table.
    function automatic logic [95:0] ref_execute(input logic [31:0] w, input bit z);
        longint unsigned wl;
        longint unsigned cw;
        logic [63:0]     cw_bits;
        logic [31:0]     k;
        longint unsigned rd, rn, rm;
        int              fs;
        bit              setf;
        bit              taken;
        wl = w;
        rd = wl % 32;
        rn = (wl / 32) % 32;
        rm = (wl / 65536) % 32;
        cw = 0;
        k = 0;
        fs = -1;
        setf = 0;
        case (wl / (2**21))
            'b10001011000: fs = 2;
            'b11001011000: fs = 6;
            'b10001010000: fs = 0;
            'b10101010000: fs = 1;
            'b11001010000: fs = 3;
            'b10101011000: begin fs = 2; setf = 1; end
            'b11101011000: begin fs = 6; setf = 1; end
            default: ;
        endcase
        if (fs >= 0) begin
            cw = rd + rn * 32 + rm * 1024 + fs * 32768 + 2**20 + setf * 2**29;
        end else begin
            case (wl / (2**22))
                'b1001000100: fs = 2;
                'b1101000100: fs = 6;
                'b1001001000: fs = 0;
                'b1011001000: fs = 1;
                'b1101001000: fs = 3;
                default: ;
            endcase
            if (fs >= 0) begin
                cw = rd + rn * 32 + fs * 32768 + 2**20 + 2**21;
                k  = 32'((wl / 1024) % 4096);
            end else if (wl / (2**21) == 'b11111000010) begin
                cw = rd + rn * 32 + 2 * 32768 + 2**20 + 2**21 + 2**23 + 2**24;
                k  = sext((wl / 4096) % 512, 9);
            end else if (wl / (2**21) == 'b11111000000) begin
                cw = rn * 32 + rd * 1024 + 2 * 32768 + 2**21 + 2**22;
                k  = sext((wl / 4096) % 512, 9);
            end else if (wl / (2**26) == 5) begin
                cw = 2 * 2**27;
                k  = sext(wl % (2**26), 26);
            end else if (wl / (2**24) == 'hB4 || wl / (2**24) == 'hB5) begin
                taken = (wl / (2**24) == 'hB4) ? z : !z;
                cw = 31 * 32 + rd * 1024 + 2 * 32768 + (taken ? 2 * 2**27 : 0);
                k  = sext((wl / 32) % (2**19), 19);
            end
        end
        cw_bits = cw;
        return {cw_bits, k};
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [10:0] r_ops [7];
        logic [9:0]  i_ops [5];
        logic [31:0] w;
        int          kind;
        r_ops = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000,
                  11'b11001010000, 11'b10101011000, 11'b11101011000};
        i_ops = '{10'b1001000100, 10'b1101000100, 10'b1001001000, 10'b1011001000,
                  10'b1101001000};
        w = $urandom;
        kind = $urandom_range(0, 13);
        case (kind)
            0, 1, 2, 3, 4, 5, 6: w[31:21] = r_ops[kind];
            7:  w[31:22] = i_ops[$urandom_range(0, 4)];
            8:  w[31:21] = 11'b11111000010;
            9:  w[31:21] = 11'b11111000000;
            10: w[31:26] = 6'b000101;
            11: w[31:24] = 8'b10110100;
            12: w[31:24] = 8'b10110101;
            default: ;
        endcase
        return w;
    endfunction

    task automatic check_output(input string name, input logic [63:0] e_con, input logic [31:0] e_out);
        checks++;
        if (con !== e_con || out !== e_out) begin
            errors++;
            $display("[TB] FAIL %s: got con=%h out=%h, expected con=%h out=%h",
                     name, con, out, e_con, e_out);
        end
    endtask

    // Drives one clock cycle's inputs and queues the response the model predicts for it.
    task automatic apply_stimulus(input logic [31:0] word, input logic [3:0] st, input bit rel,
                                  input bit use_lit, input logic [63:0] lit_con,
                                  input logic [31:0] lit_out);
        logic [95:0] exp;
        @(posedge c);
        #1;
        if (rel) r = 1'b1;
        in   = word;
        stat = st;
        if (model_fetch) begin
            exp = {64'h4C800000, 32'h0};
            model_ir = word;
            model_fetch = 1'b0;
        end else begin
            exp = use_lit ? {lit_con, lit_out} : ref_execute(model_ir, st[0]);
            model_fetch = 1'b1;
        end
        sb_q.push_back(exp);
    endtask

    always @(negedge c) begin
        logic [95:0] exp;
        if (sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            check_output("cycle", exp[95:32], exp[31:0]);
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        model_fetch = 1'b1;
        model_ir = '0;
        r = 1'b0;
        in = 32'h910193E4;
        stat = 4'h0;

        repeat (3) begin
            @(negedge c);
            #1;
            check_output("reset_hold", 64'h0, 32'h0);
        end

        apply_stimulus(32'h910193E4, 4'h0, 1'b1, 1'b0, 64'h0, 32'h0);
        apply_stimulus(32'hDEADBEEF, 4'hF, 1'b0, 1'b1, 64'h003103E4, 32'd100);
        apply_stimulus(32'h8B020246, 4'h0, 1'b0, 1'b0, 64'h0, 32'h0);
        apply_stimulus(32'h12345678, 4'h5, 1'b0, 1'b1, 64'h00110A46, 32'h0);
        apply_stimulus(32'hCB0500C1, 4'h0, 1'b0, 1'b0, 64'h0, 32'h0);
        apply_stimulus(32'h0, 4'h0, 1'b0, 1'b1, 64'h001314C1, 32'h0);
        apply_stimulus(32'hB4FFFFC3, 4'h0, 1'b0, 1'b0, 64'h0, 32'h0);
        apply_stimulus(32'h0, 4'h1, 1'b0, 1'b1, 64'h10010FE0, 32'hFFFFFFFE);
        apply_stimulus(32'hB4FFFFC3, 4'h1, 1'b0, 1'b0, 64'h0, 32'h0);
        apply_stimulus(32'h0, 4'h0, 1'b0, 1'b1, 64'h00010FE0, 32'hFFFFFFFE);

        apply_stimulus(32'hF85F8041, 4'h0, 1'b0, 1'b0, 64'h0, 32'h0);
        apply_stimulus(32'h0, 4'h0, 1'b0, 1'b0, 64'h0, 32'h0);
        @(negedge c);
        #2;
        r = 1'b0;
        #1;
        check_output("async_reset", 64'h0, 32'h0);
        model_fetch = 1'b1;
        model_ir = '0;
        @(posedge c);
        #2;
        check_output("reset_edge", 64'h0, 32'h0);

        apply_stimulus(gen_instr(), 4'($urandom), 1'b1, 1'b0, 64'h0, 32'h0);
        repeat (400) begin
            apply_stimulus(gen_instr(), 4'($urandom), 1'b0, 1'b0, 64'h0, 32'h0);
        end

        @(negedge c);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
